spu_cmd_driver: RTL and testbench
=================================

SPU_CMD_DRIVER -- requirements
Module: spu_cmd_driver

Interface
REQ-001 The block SHALL have a parameter FIFO_DEPTH, default 4, giving the number of command FIFO entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: the FIFO can accept a command; equals not-full.
REQ-006 The block SHALL have port cmd_op, input, 4 bits: the SPU Op field.
REQ-007 The block SHALL have port cmd_q, input, 4 bits: the SPU Q (input-mux) field.
REQ-008 The block SHALL have port cmd_data, input, 8 bits: the uio payload; [7:4] is the A/C nibble, [3:0] is the B/D nibble.
REQ-009 The block SHALL have port cmd_capture, input, 1 bit: the result of this command is to be returned.
REQ-010 The block SHALL have port res_valid, output, 1 bit: res_data holds a captured result.
REQ-011 The block SHALL have port res_ready, input, 1 bit: the consumer accepts the result.
REQ-012 The block SHALL have port res_data, output, 8 bits: the captured SPU output {M,N}.
REQ-013 The block SHALL have port spu_ui, output, 8 bits: drives the SPU ui_in as {Op,Q}.
REQ-014 The block SHALL have port spu_uio, output, 8 bits: drives the SPU uio_in.
REQ-015 The block SHALL have port spu_ena, output, 1 bit: drives the SPU ena.
REQ-016 The block SHALL have port spu_uo, input, 8 bits: the SPU uo_out {M,N}.
REQ-017 The block SHALL have port busy, output, 1 bit: the FSM is not IDLE or the FIFO is not empty.
REQ-018 The block SHALL have port issued_count, output, 8 bits: the number of commands issued to the SPU, wrapping modulo 256.

Function
REQ-019 A command {op,q,data,capture} SHALL be pushed into the FIFO on any edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be combinational not-full.
REQ-020 A simultaneous push and pop SHALL leave the occupancy unchanged; a push when full is impossible because cmd_ready is 0.
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT, SAMPLE and RESP.
REQ-022 IDLE: if the FIFO is non-empty at an edge, the block SHALL pop the head, register spu_ui={op,q}, spu_uio=data and spu_ena=1, and go to ISSUE.
REQ-023 ISSUE SHALL last exactly one cycle with spu_ena=1 (the SPU latches Op/Q/A..D at the exiting edge), then go to WAIT with spu_ena=0.
REQ-024 WAIT SHALL last exactly one cycle (the SPU registers M/N at the exiting edge), then go to SAMPLE.
REQ-025 SAMPLE SHALL last one cycle; at the exiting edge the block SHALL set res_data<=spu_uo and increment issued_count.
- If capture=1: set res_valid<=1 and go to RESP.
- Else, if the FIFO is non-empty: pop and go directly to ISSUE.
- Else: go to IDLE.
REQ-026 RESP SHALL hold res_valid=1 with res_data stable until an edge with res_ready=1.
- At that edge: res_valid<=0, then ISSUE (pop) if the FIFO is non-empty, else IDLE.
REQ-027 spu_ena SHALL be 1 only during ISSUE cycles, so the SPU holds Op and A..D between commands and M/N stay stable for chained Q=10xx (load from M/N) commands.
REQ-028 spu_ui and spu_uio SHALL hold the last issued values outside ISSUE and never change while spu_ena=1.
REQ-029 The minimum command period SHALL be 3 cycles (ISSUE, WAIT, SAMPLE) when capture=0 and the FIFO is backlogged.
- Latency from the push edge to res_valid rising SHALL be 4 edges when the block is idle and empty.
REQ-030 issued_count SHALL wrap 255->0 without any other effect.
REQ-031 A command with capture=0 SHALL never assert res_valid.

Reset
REQ-032 On an edge with rst_n=0 the block SHALL:
- set state to IDLE and empty the FIFO;
- set spu_ui=0x00, spu_uio=0x00, spu_ena=0;
- set res_valid=0, res_data=0x00, issued_count=0;
- yield busy=0 and cmd_ready=1.
REQ-033 Reset asserted in any state, including mid-ISSUE or RESP, SHALL abort the in-flight command with no res_valid pulse; queued commands SHALL be discarded.

Verification
REQ-034 Single command: push op=0x6, q=0x6, data=0x35, capture=1 into an idle block -> spu_ena=1 for exactly one cycle with spu_ui=0x66, spu_uio=0x35; res_valid rises 4 edges after the push; res_data = SPU model uo_out; issued_count=1.
REQ-035 Backlog: push 4 commands with capture=0 back-to-back -> cmd_ready=0 at full; spu_ena pulses every 3 cycles; issued_count=4; res_valid never asserts.
REQ-036 Backpressure: capture=1 with res_ready held 0 for 10 cycles, a second command queued -> res_data stable, no second spu_ena pulse until the res_ready handshake; issue follows on the next cycle.
REQ-037 Chaining: q=0x7 with data=0x21, then q=0xA with capture=1 -> the SPU model A/B are loaded from M/N of the first result; the returned value matches the model.
REQ-038 Reset mid-RESP and mid-ISSUE -> all outputs at reset values the next cycle; busy=0; no res_valid; issued_count=0.
REQ-039 Wrap: issue 256 commands -> issued_count returns to 0x00.

Source files
------------

// File: rtl/spu_cmd_driver.sv
// Command driver for an SPU tile: queues {op,q,data,capture} commands in a small FIFO
// and sequences each through ISSUE/WAIT/SAMPLE, optionally returning the SPU result.
module spu_cmd_driver #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [3:0] cmd_op,
   input  logic [3:0] cmd_q,
   input  logic [7:0] cmd_data,
   input  logic       cmd_capture,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [7:0] spu_ui,
   output logic [7:0] spu_uio,
   output logic       spu_ena,
   input  logic [7:0] spu_uo,
   output logic       busy,
   output logic [7:0] issued_count
);

   // FIFO_DEPTH must be a power of two, at least 2.
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

   typedef struct packed {
      logic [3:0] op;
      logic [3:0] q;
      logic [7:0] data;
      logic       capture;
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      SAMPLE,
      RESP
   } state_t;

   state_t state, next_state;

   cmd_t           fifo_mem [FIFO_DEPTH];
   cmd_t           head;
   logic [PTR_W:0] wr_ptr, rd_ptr;
   logic           fifo_empty, fifo_full;
   logic           push, pop;
   logic           sample_en, resp_done;
   logic           cur_capture;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign cmd_ready  = !fifo_full;
   assign push       = cmd_valid && cmd_ready;
   assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
   assign busy       = (state != IDLE) || !fifo_empty;

   // NOTE: FIFO storage has no reset; the pointers alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[PTR_W-1:0]] <= {cmd_op, cmd_q, cmd_data, cmd_capture};
      end
   end

   // NOTE: sequential state is always updated with non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      sample_en  = 1'b0;
      resp_done  = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = ISSUE;
            end
         end
         ISSUE:  next_state = WAIT;
         WAIT:   next_state = SAMPLE;
         SAMPLE: begin
            sample_en = 1'b1;
            if (cur_capture) begin
               next_state = RESP;
            end else if (!fifo_empty) begin
               pop        = 1'b1;
               next_state = ISSUE;
            end else begin
               next_state = IDLE;
            end
         end
         RESP: begin
            if (res_ready) begin
               resp_done = 1'b1;
               if (!fifo_empty) begin
                  pop        = 1'b1;
                  next_state = ISSUE;
               end else begin
                  next_state = IDLE;
               end
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // ISSUE is only ever entered through a pop, so the enable simply follows pop.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spu_ui       <= 8'h00;
         spu_uio      <= 8'h00;
         spu_ena      <= 1'b0;
         cur_capture  <= 1'b0;
         res_valid    <= 1'b0;
         res_data     <= 8'h00;
         issued_count <= 8'h00;
      end else begin
         spu_ena <= pop;
         if (pop) begin
            spu_ui      <= {head.op, head.q};
            spu_uio     <= head.data;
            cur_capture <= head.capture;
         end
         if (sample_en) begin
            res_data     <= spu_uo;
            issued_count <= issued_count + 8'd1;
            if (cur_capture) res_valid <= 1'b1;
         end
         if (resp_done) res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_spu_cmd_driver.sv
// Directed bench for spu_cmd_driver with a small behavioural SPU tile attached.
module tb_spu_cmd_driver;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cmd_op = 4'h0;
   logic [3:0] cmd_q = 4'h0;
   logic [7:0] cmd_data = 8'h00;
   logic       cmd_capture = 1'b0;
   logic       res_valid;
   logic       res_ready = 1'b0;
   logic [7:0] res_data;
   logic [7:0] spu_ui;
   logic [7:0] spu_uio;
   logic       spu_ena;
   logic [7:0] spu_uo;
   logic       busy;
   logic [7:0] issued_count;

   int vectors = 0;
   int miscompares = 0;
   int rv_count = 0;
   int ena_count = 0;

   spu_cmd_driver #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_q(cmd_q), .cmd_data(cmd_data), .cmd_capture(cmd_capture),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .spu_ui(spu_ui), .spu_uio(spu_uio), .spu_ena(spu_ena), .spu_uo(spu_uo),
      .busy(busy), .issued_count(issued_count)
   );

   always #5 clk = ~clk;

   // SPU tile: latches Op/A/B on ena (Q=10xx loads A/B from M/N), registers
   // M = A+B+Op and N = A^B every edge.
   logic [3:0] m_op, m_a, m_b;
   logic [7:0] m_mn;
   assign spu_uo = m_mn;
   always @(posedge clk) begin
      if (!rst_n) begin
         m_op <= 4'h0; m_a <= 4'h0; m_b <= 4'h0; m_mn <= 8'h00;
      end else begin
         if (spu_ena) begin
            m_op <= spu_ui[7:4];
            if (spu_ui[3:2] == 2'b10) begin
               m_a <= m_mn[7:4]; m_b <= m_mn[3:0];
            end else begin
               m_a <= spu_uio[7:4]; m_b <= spu_uio[3:0];
            end
         end
         m_mn <= {m_a + m_b + m_op, m_a ^ m_b};
      end
   end

   always @(negedge clk) begin
      if (res_valid) rv_count++;
      if (spu_ena) ena_count++;
   end

   task automatic push_cmd(input logic [3:0] op, input logic [3:0] q,
                           input logic [7:0] data, input logic cap);
      logic accepted;
      accepted = 1'b0;
      cmd_op = op; cmd_q = q; cmd_data = data; cmd_capture = cap; cmd_valid = 1'b1;
      for (int i = 0; i < 60 && !accepted; i++) begin
         accepted = cmd_ready;
         @(posedge clk); #1;
      end
      cmd_valid = 1'b0;
      vectors++;
      if (accepted !== 1'b1) begin
         $display("FAIL push_accept: got %b want 1", accepted); miscompares++;
      end
   endtask

   task automatic wait_idle(input int max_cycles);
      for (int i = 0; i < max_cycles && busy; i++) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (busy !== 1'b0) begin
         $display("FAIL wait_idle_timeout: busy got %b want 0", busy); miscompares++;
      end
   endtask

   task automatic wait_res_valid(input int max_cycles);
      for (int i = 0; i < max_cycles && !res_valid; i++) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (res_valid !== 1'b1) begin
         $display("FAIL wait_res_valid_timeout: got %b want 1", res_valid); miscompares++;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      logic [36:0] got, want;
      got  = {spu_ui, spu_uio, spu_ena, res_valid, res_data, issued_count, busy, cmd_ready};
      want = {8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
      vectors++;
      if (got !== want) begin
         $display("FAIL %s: got %h want %h", tag, got, want); miscompares++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_state");
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int ena_at, ena_n, valid_at;
      logic [7:0] ui_seen, uio_seen;
      ena_at = -1; ena_n = 0; valid_at = -1; ui_seen = 8'h00; uio_seen = 8'h00;
      push_cmd(4'h6, 4'h6, 8'h35, 1'b1);
      vectors++;
      if (busy !== 1'b1) begin
         $display("FAIL single_busy_queued: got %b want 1", busy); miscompares++;
      end
      for (int c = 1; c <= 10 && valid_at < 0; c++) begin
         @(posedge clk); #1;
         if (spu_ena) begin
            ena_n++; ena_at = c; ui_seen = spu_ui; uio_seen = spu_uio;
         end
         if (res_valid) valid_at = c;
      end
      vectors++;
      if (ena_at !== 1 || ena_n !== 1) begin
         $display("FAIL single_ena_pulse: at %0d count %0d want at 1 count 1", ena_at, ena_n);
         miscompares++;
      end
      vectors++;
      if ({ui_seen, uio_seen} !== 16'h6635) begin
         $display("FAIL single_ui_uio: got %h want 6635", {ui_seen, uio_seen}); miscompares++;
      end
      vectors++;
      if (valid_at !== 4) begin
         $display("FAIL single_latency: got %0d want 4", valid_at); miscompares++;
      end
      vectors++;
      if (res_data !== 8'hE6) begin
         $display("FAIL single_res_data: got %h want e6", res_data); miscompares++;
      end
      vectors++;
      if (issued_count !== 8'd1) begin
         $display("FAIL single_issued: got %0d want 1", issued_count); miscompares++;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      vectors++;
      if ({res_valid, busy, spu_ui} !== {1'b0, 1'b0, 8'h66}) begin
         $display("FAIL single_after_handshake: got %b %b %h want 0 0 66", res_valid, busy, spu_ui);
         miscompares++;
      end
   endtask

   task automatic test_backlog();
      int n_push, n_ena, rv_before;
      int ena_c [8];
      logic [7:0] ui_seen [8];
      logic ready_pre, ready_after_last;
      n_push = 0; n_ena = 0; ready_after_last = 1'b1; rv_before = rv_count;
      for (int c = 0; c < 30; c++) begin
         if (n_push < 6) begin
            cmd_valid = 1'b1; cmd_op = 4'(n_push); cmd_q = 4'(n_push + 1);
            cmd_data = 8'(8'h30 + n_push); cmd_capture = 1'b0;
         end else begin
            cmd_valid = 1'b0;
         end
         ready_pre = cmd_ready;
         @(posedge clk); #1;
         if (cmd_valid && ready_pre) begin
            n_push++;
            if (n_push == 6) ready_after_last = cmd_ready;
         end
         if (spu_ena && n_ena < 8) begin
            ena_c[n_ena] = c; ui_seen[n_ena] = spu_ui; n_ena++;
         end
      end
      cmd_valid = 1'b0;
      vectors++;
      if (ready_after_last !== 1'b0) begin
         $display("FAIL backlog_full_ready: got %b want 0", ready_after_last); miscompares++;
      end
      vectors++;
      if (n_ena !== 6) begin
         $display("FAIL backlog_pulses: got %0d want 6", n_ena); miscompares++;
      end
      for (int k = 0; k < n_ena && k < 6; k++) begin
         logic [7:0] exp_ui;
         exp_ui = {4'(k), 4'(k + 1)};
         vectors++;
         if (ui_seen[k] !== exp_ui || ena_c[k] !== 1 + 3 * k) begin
            $display("FAIL backlog_issue_%0d: ui %h cycle %0d want ui %h cycle %0d",
                     k, ui_seen[k], ena_c[k], exp_ui, 1 + 3 * k);
            miscompares++;
         end
      end
      wait_idle(10);
      vectors++;
      if (issued_count !== 8'd7 || rv_count !== rv_before) begin
         $display("FAIL backlog_count: issued %0d res_valid cycles %0d want 7 0",
                  issued_count, rv_count - rv_before);
         miscompares++;
      end
   endtask

   task automatic test_backpressure();
      int ena_before;
      res_ready = 1'b0;
      push_cmd(4'h3, 4'h1, 8'h12, 1'b1);
      push_cmd(4'h5, 4'h2, 8'h44, 1'b1);
      wait_res_valid(10);
      ena_before = ena_count;
      for (int c = 0; c < 10; c++) begin
         vectors++;
         if ({res_valid, res_data, spu_ena} !== {1'b1, 8'h63, 1'b0}) begin
            $display("FAIL backpressure_hold_%0d: got %b %h %b want 1 63 0",
                     c, res_valid, res_data, spu_ena);
            miscompares++;
         end
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      vectors++;
      if ({res_valid, spu_ena, spu_ui, spu_uio} !== {1'b0, 1'b1, 8'h52, 8'h44} ||
          ena_count !== ena_before) begin
         $display("FAIL backpressure_release: got %b %b %h %h extra pulses %0d want 0 1 52 44 0",
                  res_valid, spu_ena, spu_ui, spu_uio, ena_count - ena_before);
         miscompares++;
      end
      wait_res_valid(6);
      vectors++;
      if (res_data !== 8'hD0) begin
         $display("FAIL backpressure_second_data: got %h want d0", res_data); miscompares++;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      wait_idle(5);
      vectors++;
      if (issued_count !== 8'd9) begin
         $display("FAIL backpressure_issued: got %0d want 9", issued_count); miscompares++;
      end
   endtask

   task automatic test_chaining();
      int rv_before;
      rv_before = rv_count;
      push_cmd(4'h1, 4'h7, 8'h21, 1'b0);
      push_cmd(4'h2, 4'hA, 8'hFF, 1'b1);
      wait_res_valid(15);
      vectors++;
      if (res_data !== 8'h97) begin
         $display("FAIL chain_res_data: got %h want 97", res_data); miscompares++;
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      wait_idle(5);
      vectors++;
      if (issued_count !== 8'd11 || rv_count - rv_before !== 1) begin
         $display("FAIL chain_counts: issued %0d valid cycles %0d want 11 1",
                  issued_count, rv_count - rv_before);
         miscompares++;
      end
   endtask

   task automatic quiet_after_reset(input string tag);
      int rv_before, ena_before;
      rv_before = rv_count; ena_before = ena_count;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      vectors++;
      if (rv_count !== rv_before || ena_count !== ena_before || busy !== 1'b0) begin
         $display("FAIL %s: valid cycles %0d ena cycles %0d busy %b want 0 0 0", tag,
                  rv_count - rv_before, ena_count - ena_before, busy);
         miscompares++;
      end
   endtask

   task automatic test_reset_mid();
      push_cmd(4'h6, 4'h6, 8'h35, 1'b1);
      push_cmd(4'h1, 4'h1, 8'h11, 1'b0);
      wait_res_valid(10);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("reset_mid_resp");
      quiet_after_reset("reset_mid_resp_quiet");

      push_cmd(4'h2, 4'h3, 8'h56, 1'b1);
      push_cmd(4'h4, 4'h5, 8'h67, 1'b1);
      for (int i = 0; i < 10 && !spu_ena; i++) begin
         @(posedge clk); #1;
      end
      vectors++;
      if (spu_ena !== 1'b1) begin
         $display("FAIL reset_mid_issue_reach: spu_ena got %b want 1", spu_ena); miscompares++;
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs("reset_mid_issue");
      quiet_after_reset("reset_mid_issue_quiet");
   endtask

   task automatic test_wrap();
      int rv_before;
      rv_before = rv_count;
      for (int k = 0; k < 255; k++) begin
         push_cmd(4'(k), 4'h0, 8'(k), 1'b0);
      end
      wait_idle(20);
      vectors++;
      if (issued_count !== 8'hFF) begin
         $display("FAIL wrap_255: got %h want ff", issued_count); miscompares++;
      end
      push_cmd(4'h9, 4'h0, 8'h99, 1'b0);
      wait_idle(10);
      vectors++;
      if (issued_count !== 8'h00 || rv_count !== rv_before) begin
         $display("FAIL wrap_zero: issued %h valid cycles %0d want 00 0",
                  issued_count, rv_count - rv_before);
         miscompares++;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backlog();
      test_backpressure();
      test_chaining();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
